caravel_host_bridge: RTL and testbench

//  Parametrised Caravel-to-user-space Wishbone bridge. Accepts Caravel's 32-bit slave port and decodes window
//  adr[31:28]==USER_SPACE_ADDRESS, sub-window adr[27:24]. Routes each access to one of NUM_TARGETS master ports
//  or to a local config/status register file. Adds per-target enable, bus-error/timeout abort, sticky status and irq.

---
 rtl/caravel_host_bridge.sv | 217 +++++++++++++++++++++
 tb/tb_caravel_host_bridge.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/caravel_host_bridge.sv
// caravel_host_bridge: claims one 256 MB window of Caravel's Wishbone slave port and forwards
// each access to one of NUM_TARGETS user-space master ports or to a small local register file.
// Per-target enables, bus-error and timeout aborts, sticky error status and a level irq are included.
module caravel_host_bridge #(
    parameter int          NUM_TARGETS             = 4,
    parameter logic [3:0]  USER_SPACE_ADDRESS      = 4'h3,
    parameter logic [3:0]  HOST_PERIPHERAL_ADDRESS = 4'hF,
    parameter int          TIMEOUT_WIDTH           = 16,
    parameter int          DEFAULT_TIMEOUT         = 1023,
    parameter logic [15:0] PART_ID                 = 16'hCD55,
    parameter logic [3:0]  VERSION_ID              = 4'h1
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_we_i,
    input  logic [3:0]                  wbs_sel_i,
    input  logic [31:0]                 wbs_adr_i,
    input  logic [31:0]                 wbs_data_i,
    output logic                        wbs_ack_o,
    output logic [31:0]                 wbs_data_o,
    output logic [NUM_TARGETS-1:0]      tgt_cyc_o,
    output logic [NUM_TARGETS-1:0]      tgt_stb_o,
    output logic                        tgt_we_o,
    output logic [3:0]                  tgt_sel_o,
    output logic [23:0]                 tgt_adr_o,
    output logic [31:0]                 tgt_data_o,
    input  logic [NUM_TARGETS-1:0]      tgt_ack_i,
    input  logic [NUM_TARGETS-1:0]      tgt_stall_i,
    input  logic [NUM_TARGETS-1:0]      tgt_err_i,
    input  logic [32*NUM_TARGETS-1:0]   tgt_data_i,
    output logic                        irq_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TO_ONE = TIMEOUT_WIDTH'(1);

    state_t                   state, state_next;

    // Local register state
    logic [NUM_TARGETS-1:0]   tgt_en;
    logic                     irq_en;
    logic [TIMEOUT_WIDTH-1:0] timeout;
    logic [2:0]               err_flags;     // {timeout, bus_err, decode_err}
    logic [3:0]               err_win;
    logic [7:0]               err_cnt;

    // Access bookkeeping
    logic [3:0]               win_q;
    logic [TIMEOUT_WIDTH-1:0] to_cnt, to_next;

    // Request decode and target response
    logic                     req, is_local, tgt_go, dec_err;
    logic [3:0]               win;
    logic [NUM_TARGETS-1:0]   win_oh;
    logic                     t_ack, t_err, t_stall, t_to, t_done;
    logic [31:0]              t_rdata, local_rdata;
    logic                     local_wr, wr_status, wr_tgt_en, wr_timeout;
    logic [2:0]               flag_clr;
    logic                     ev_dec, ev_bus, ev_to, ev_any;
    logic [3:0]               ev_win;

    // Byte-lane merge of a write into an existing 32-bit register image.
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur, input logic [31:0] wd,
                                                input logic [3:0] sel);
        merge_bytes = cur;
        for (int b = 0; b < 4; b++)
            if (sel[b]) merge_bytes[8*b +: 8] = wd[8*b +: 8];
    endfunction

    // Decode the incoming Caravel request into local / target / decode-error.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
        win_oh   = '0;
        win      = wbs_adr_i[27:24];
        req      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == USER_SPACE_ADDRESS);
        is_local = (win == HOST_PERIPHERAL_ADDRESS);
        for (int i = 0; i < NUM_TARGETS; i++)
            win_oh[i] = (win == 4'(i));
        tgt_go   = req & ~is_local & (|(win_oh & tgt_en));
        dec_err  = req & ~is_local & ~tgt_go;
    end

    // Select the active target's response; tgt_cyc_o is one-hot while an access is open.
    always_comb begin
        t_rdata = '0;
        for (int i = 0; i < NUM_TARGETS; i++)
            if (tgt_cyc_o[i]) t_rdata = t_rdata | tgt_data_i[32*i +: 32];
        t_ack   = |(tgt_ack_i & tgt_cyc_o);
        t_err   = |(tgt_err_i & tgt_cyc_o);
        t_stall = |(tgt_stall_i & tgt_stb_o);
        to_next = to_cnt + TO_ONE;
        // ack/err on the timeout edge take precedence over the abort
        t_to    = (timeout != '0) && (to_next == timeout) && !t_ack && !t_err;
        t_done  = (state == ACCESS) && (t_ack || t_err || t_to);
    end

    // Local register read mux, write strobes and error events.
    always_comb begin
        case (wbs_adr_i[3:2])
            2'd0:    local_rdata = {VERSION_ID, 4'h0, 8'(NUM_TARGETS), PART_ID};
            2'd1:    local_rdata = {16'h0, err_cnt, err_win, 1'b0, err_flags};
            2'd2:    local_rdata = {irq_en, {(31-NUM_TARGETS){1'b0}}, tgt_en};
            default: local_rdata = 32'(timeout);
        endcase
        local_wr   = (state == IDLE) && req && is_local && wbs_we_i;
        wr_status  = local_wr && (wbs_adr_i[3:2] == 2'd1);
        wr_tgt_en  = local_wr && (wbs_adr_i[3:2] == 2'd2);
        wr_timeout = local_wr && (wbs_adr_i[3:2] == 2'd3);
        flag_clr   = (wr_status && wbs_sel_i[0]) ? wbs_data_i[2:0] : 3'b000;
        ev_dec     = (state == IDLE) && dec_err;
        ev_bus     = (state == ACCESS) && t_err;
        ev_to      = (state == ACCESS) && t_to;
        ev_any     = ev_dec || ev_bus || ev_to;
        ev_win     = ev_dec ? win : win_q;
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!wb_rst_ni) state <= IDLE;
        else            state <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = tgt_go ? ACCESS : RESPOND;
            ACCESS:  if (t_done) state_next = RESPOND;
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus-facing registers: Caravel response, downstream request and timeout counter.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o  <= 1'b0;
            wbs_data_o <= '0;
            tgt_cyc_o  <= '0;
            tgt_stb_o  <= '0;
            tgt_we_o   <= 1'b0;
            tgt_sel_o  <= '0;
            tgt_adr_o  <= '0;
            tgt_data_o <= '0;
            to_cnt     <= '0;
            win_q      <= '0;
        end else begin
            wbs_ack_o <= (state_next == RESPOND);
            case (state)
                IDLE: if (req) begin
                    win_q <= win;
                    if (tgt_go) begin
                        tgt_cyc_o  <= win_oh;
                        tgt_stb_o  <= win_oh;
                        tgt_we_o   <= wbs_we_i;
                        tgt_sel_o  <= wbs_sel_i;
                        tgt_adr_o  <= wbs_adr_i[23:0];
                        tgt_data_o <= wbs_data_i;
                        to_cnt     <= '0;
                    end else begin
                        wbs_data_o <= is_local ? local_rdata : 32'hFFFF_FFFF;
                    end
                end
                ACCESS: if (t_done) begin
                    tgt_cyc_o  <= '0;
                    tgt_stb_o  <= '0;
                    tgt_we_o   <= 1'b0;
                    tgt_sel_o  <= '0;
                    tgt_adr_o  <= '0;
                    tgt_data_o <= '0;
                    wbs_data_o <= (t_err || t_to) ? 32'hFFFF_FFFF : t_rdata;
                end else begin
                    to_cnt <= to_next;
                    if (!t_stall) tgt_stb_o <= '0;
                end
                default: wbs_data_o <= '0;
            endcase
        end
    end

    // Local configuration and sticky status registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        // NOTE: these are a handful of control flops, not a storage array, so all get a reset value.
        if (!wb_rst_ni) begin
            tgt_en    <= '1;
            irq_en    <= 1'b0;
            timeout   <= TIMEOUT_WIDTH'(DEFAULT_TIMEOUT);
            err_flags <= '0;
            err_win   <= '0;
            err_cnt   <= '0;
        end else begin
            if (wr_tgt_en) begin
                tgt_en <= NUM_TARGETS'(merge_bytes(32'(tgt_en), wbs_data_i, wbs_sel_i));
                if (wbs_sel_i[3]) irq_en <= wbs_data_i[31];
            end
            if (wr_timeout)
                timeout <= TIMEOUT_WIDTH'(merge_bytes(32'(timeout), wbs_data_i, wbs_sel_i));
            if (wr_status && wbs_sel_i[1] && wbs_data_i[8]) begin
                err_cnt <= '0;
                err_win <= '0;
            end
            err_flags <= (err_flags & ~flag_clr) | {ev_to, ev_bus, ev_dec};
            // error event is written last so it wins over a same-cycle clear
            if (ev_any) begin
                err_win <= ev_win;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign irq_o = irq_en & (|err_flags);

endmodule

// File: tb/tb_caravel_host_bridge.sv
// tb_caravel_host_bridge: directed vectors for the Caravel host bridge with hand-computed expectations.
module tb_caravel_host_bridge;

    localparam int NT = 4;

    localparam logic [31:0] ID_VAL  = 32'h1004_CD55;
    localparam logic [31:0] A_ID    = 32'h3F00_0000;
    localparam logic [31:0] A_STAT  = 32'h3F00_0004;
    localparam logic [31:0] A_TGTEN = 32'h3F00_0008;
    localparam logic [31:0] A_TO    = 32'h3F00_000C;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_ni = 1'b0;
    logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i, wbs_data_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_data_o;
    logic [NT-1:0]     tgt_cyc_o, tgt_stb_o;
    logic              tgt_we_o;
    logic [3:0]        tgt_sel_o;
    logic [23:0]       tgt_adr_o;
    logic [31:0]       tgt_data_o;
    logic [NT-1:0]     tgt_ack_i, tgt_stall_i, tgt_err_i;
    logic [32*NT-1:0]  tgt_data_i;
    logic              irq_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    always #5 wb_clk_i = ~wb_clk_i;

    caravel_host_bridge dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_ni   (wb_rst_ni),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_data_i  (wbs_data_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_data_o  (wbs_data_o),
        .tgt_cyc_o   (tgt_cyc_o),
        .tgt_stb_o   (tgt_stb_o),
        .tgt_we_o    (tgt_we_o),
        .tgt_sel_o   (tgt_sel_o),
        .tgt_adr_o   (tgt_adr_o),
        .tgt_data_o  (tgt_data_o),
        .tgt_ack_i   (tgt_ack_i),
        .tgt_stall_i (tgt_stall_i),
        .tgt_err_i   (tgt_err_i),
        .tgt_data_i  (tgt_data_i),
        .irq_o       (irq_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // One Caravel transfer, started and finished one time unit after a rising edge.
    // lat = edges until ack was seen (64 if it never came); tcyc = sampled cycles with any tgt_cyc_o.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd, output int lat,
                           output int tcyc);
        wbs_cyc_i  = 1'b1;
        wbs_stb_i  = 1'b1;
        wbs_we_i   = we;
        wbs_adr_i  = adr;
        wbs_data_i = dat;
        wbs_sel_i  = sel;
        lat  = 0;
        tcyc = 0;
        do begin
            @(posedge wb_clk_i); #1;
            lat++;
            if (tgt_cyc_o != '0) tcyc++;
        end while (!wbs_ack_o && lat < 64);
        rd = wbs_data_o;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(posedge wb_clk_i); #1;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] rd;
        int lat, tcyc;
        wb_xfer(1'b1, adr, dat, sel, rd, lat, tcyc);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        int lat, tcyc;
        wb_xfer(1'b0, adr, 32'h0, 4'hF, rd, lat, tcyc);
        check(name, rd, exp);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[10];
        logic [31:0] rd;
        int          lat, tcyc, acks;

        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = '0; wbs_adr_i = '0; wbs_data_i = '0;
        tgt_ack_i = '0; tgt_stall_i = '0; tgt_err_i = '0;
        tgt_data_i = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF};

        //           we    adr      data           sel    chk   expected
        vecs[0] = '{1'b0, A_ID,    32'h0,         4'hF, 1'b1, ID_VAL};
        vecs[1] = '{1'b0, A_STAT,  32'h0,         4'hF, 1'b1, 32'h0000_0000};
        vecs[2] = '{1'b0, A_TGTEN, 32'h0,         4'hF, 1'b1, 32'h0000_000F};
        vecs[3] = '{1'b0, A_TO,    32'h0,         4'hF, 1'b1, 32'h0000_03FF};
        vecs[4] = '{1'b1, A_TO,    32'h0001_2345, 4'h1, 1'b0, 32'h0};
        vecs[5] = '{1'b0, A_TO,    32'h0,         4'hF, 1'b1, 32'h0000_0345};
        vecs[6] = '{1'b1, A_ID,    32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
        vecs[7] = '{1'b0, A_ID,    32'h0,         4'hF, 1'b1, ID_VAL};
        vecs[8] = '{1'b1, A_TO,    32'h0000_0040, 4'hF, 1'b0, 32'h0};
        vecs[9] = '{1'b0, A_TO,    32'h0,         4'hF, 1'b1, 32'h0000_0040};

        // Reset state
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("rst_ack", 32'(wbs_ack_o), 32'h0);
        check("rst_data", wbs_data_o, 32'h0);
        check("rst_cyc", 32'(tgt_cyc_o), 32'h0);
        check("rst_stb", 32'(tgt_stb_o), 32'h0);
        check("rst_adr", 32'(tgt_adr_o), 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        @(posedge wb_clk_i); #1;

        // Local register table
        for (int i = 0; i < 10; i++) begin
            wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, lat, tcyc);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
            check($sformatf("vec%0d_tcyc", i), 32'(tcyc), 32'd0);
            if (vecs[i].chk) check($sformatf("vec%0d_data", i), rd, vecs[i].exp);
        end

        // Request outside the user window is ignored
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h2F00_0000;
        acks = 0; tcyc = 0;
        repeat (6) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) acks++;
            if (tgt_cyc_o != '0) tcyc++;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        check("outside_ack", 32'(acks), 32'd0);
        check("outside_cyc", 32'(tcyc), 32'd0);
        @(posedge wb_clk_i); #1;

        // Target 0 read with immediate ack: data slice 0 is returned
        tgt_ack_i = 4'b0001;
        wb_xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, rd, lat, tcyc);
        tgt_ack_i = '0;
        check("t0_data", rd, 32'hDEAD_BEEF);
        check("t0_lat", 32'(lat), 32'd2);
        check("t0_tcyc", 32'(tcyc), 32'd1);

        // Target 1 write with stall: stb held while stalled, cyc held until ack
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h3100_0010; wbs_data_i = 32'hA5A5_5A5A; wbs_sel_i = 4'b0011;
        tgt_stall_i = 4'b0010;
        @(posedge wb_clk_i); #1;
        check("w1_cyc", 32'(tgt_cyc_o), 32'h2);
        check("w1_stb", 32'(tgt_stb_o), 32'h2);
        check("w1_adr", 32'(tgt_adr_o), 32'h0000_0010);
        check("w1_we", 32'(tgt_we_o), 32'h1);
        check("w1_sel", 32'(tgt_sel_o), 32'h3);
        check("w1_wdata", tgt_data_o, 32'hA5A5_5A5A);
        @(posedge wb_clk_i); #1;
        check("w1_stb_stalled", 32'(tgt_stb_o), 32'h2);
        @(posedge wb_clk_i); #1;
        tgt_stall_i = '0;
        @(posedge wb_clk_i); #1;
        check("w1_stb_drop", 32'(tgt_stb_o), 32'h0);
        check("w1_cyc_hold", 32'(tgt_cyc_o), 32'h2);
        check("w1_no_early_ack", 32'(wbs_ack_o), 32'h0);
        tgt_ack_i = 4'b0010;
        @(posedge wb_clk_i); #1;
        acks = wbs_ack_o ? 1 : 0;
        check("w1_cyc_end", 32'(tgt_cyc_o), 32'h0);
        tgt_ack_i = '0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        repeat (3) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) acks++;
        end
        check("w1_ack_once", 32'(acks), 32'd1);
        check("w1_idle_we", 32'(tgt_we_o), 32'h0);
        check("w1_idle_adr", 32'(tgt_adr_o), 32'h0);
        rd_chk("w1_status", A_STAT, 32'h0);

        // Timeout on target 2
        wr(A_TO, 32'h0000_0005, 4'hF);
        wb_xfer(1'b0, 32'h3200_0000, 32'h0, 4'hF, rd, lat, tcyc);
        check("to_data", rd, 32'hFFFF_FFFF);
        check("to_cyc_len", 32'(tcyc), 32'd5);
        check("to_lat", 32'(lat), 32'd6);
        rd_chk("to_status", A_STAT, 32'h0000_0124);
        check("to_irq_off", 32'(irq_o), 32'h0);
        wr(A_TGTEN, 32'h8000_000F, 4'hF);
        check("to_irq_on", 32'(irq_o), 32'h1);
        wr(A_STAT, 32'h0000_0007, 4'b0001);
        rd_chk("to_w1c", A_STAT, 32'h0000_0120);
        check("to_irq_clr", 32'(irq_o), 32'h0);

        // Decode errors: disabled target and unmapped sub-window
        wr(A_TGTEN, 32'h0000_000E, 4'b0001);
        rd_chk("de_tgten", A_TGTEN, 32'h8000_000E);
        wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, rd, lat, tcyc);
        check("de0_data", rd, 32'hFFFF_FFFF);
        check("de0_lat", 32'(lat), 32'd1);
        check("de0_tcyc", 32'(tcyc), 32'd0);
        rd_chk("de0_status", A_STAT, 32'h0000_0201);
        wb_xfer(1'b0, 32'h3700_0000, 32'h0, 4'hF, rd, lat, tcyc);
        check("de7_data", rd, 32'hFFFF_FFFF);
        check("de7_lat", 32'(lat), 32'd1);
        rd_chk("de7_status", A_STAT, 32'h0000_0371);
        check("de_irq", 32'(irq_o), 32'h1);

        // Target 3 ack and err on the same edge: err wins
        tgt_ack_i = 4'b1000; tgt_err_i = 4'b1000;
        wb_xfer(1'b0, 32'h3300_0000, 32'h0, 4'hF, rd, lat, tcyc);
        tgt_ack_i = '0; tgt_err_i = '0;
        check("be_data", rd, 32'hFFFF_FFFF);
        check("be_lat", 32'(lat), 32'd2);
        rd_chk("be_status", A_STAT, 32'h0000_0433);

        // Error count clear, then saturation after 256 errors
        wr(A_STAT, 32'h0000_0107, 4'b0011);
        rd_chk("sat_cleared", A_STAT, 32'h0000_0000);
        for (int i = 0; i < 256; i++)
            wb_xfer(1'b0, 32'h3700_0000, 32'h0, 4'hF, rd, lat, tcyc);
        rd_chk("sat_status", A_STAT, 32'h0000_FF71);

        // Asynchronous reset in the middle of a target access
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h3100_0000; wbs_sel_i = 4'hF;
        @(posedge wb_clk_i); #1;
        check("ar_cyc_open", 32'(tgt_cyc_o), 32'h2);
        @(posedge wb_clk_i); #2;
        wb_rst_ni = 1'b0;
        #1;
        check("ar_cyc_drop", 32'(tgt_cyc_o), 32'h0);
        check("ar_stb_drop", 32'(tgt_stb_o), 32'h0);
        check("ar_ack", 32'(wbs_ack_o), 32'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        @(posedge wb_clk_i); #1;
        rd_chk("ar_tgten", A_TGTEN, 32'h0000_000F);
        rd_chk("ar_timeout", A_TO, 32'h0000_03FF);
        rd_chk("ar_status", A_STAT, 32'h0000_0000);
        check("ar_irq", 32'(irq_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
